mux_n_1_pipe: RTL and testbench

- Parametrised successor to the 2:1 select muxes in the datapath, such as the 5-bit register-destination select.
- Selects one of NUM_IN WIDTH-bit inputs by binary select and registers the result.
- Has a valid/ready handshake and a 2-entry skid buffer, so it can sit between pipeline stages at full throughput without a combinational ready path.
- Also forwards the select value alongside the data, for downstream forwarding/hazard logic.

---
 rtl/mux_pkg.sv | 11 +
 rtl/skid_buf.sv | 71 +++++++
 rtl/mux_n_1_pipe.sv | 96 +++++++++
 tb/tb_mux_n_1_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared helpers for the parametrised select-mux family.
package mux_pkg;

    localparam int unsigned MUX_MAX_IN = 32;

    // Select width: ceil(log2(n)), never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register drives the outputs,
// skid register absorbs one extra beat so in_ready can be fully registered.
module skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept_c;
    logic             handoff_c;

    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        accept_c     = in_valid & in_ready_q;
        handoff_c    = main_valid_q & out_ready;

        if (skid_valid_q) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (handoff_c) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || handoff_c) begin
            main_valid_d = accept_c;
            if (accept_c) begin
                main_data_d = in_data;
            end
        end else if (accept_c) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = main_data_q;
    assign out_valid = main_valid_q;

endmodule

// File: rtl/mux_n_1_pipe.sv
// NUM_IN:1 binary-select mux with registered valid/ready output and select forwarding.
// Define SEL_CHECK_EN to enable the sticky out-of-range select flag (sel_err).
module mux_n_1_pipe
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH  = 5,
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    localparam int unsigned PAY_W = SEL_W + WIDTH;

    generate
        if (NUM_IN < 2 || NUM_IN > MUX_MAX_IN) begin : g_bad_num_in
            $error("mux_n_1_pipe: NUM_IN out of legal range");
        end
    endgenerate

    logic [WIDTH-1:0] sel_word_c;
    logic [PAY_W-1:0] pay_out;

    // Unmatched select codes (>= NUM_IN) fall through to all-zero data.
    always_comb begin
        sel_word_c = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word_c = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    skid_buf #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({in_sel, sel_word_c}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (pay_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign {out_sel, out_data} = pay_out;

`ifdef SEL_CHECK_EN
    logic sel_err_q, sel_err_d;
    logic sel_oob_c;
    logic accept_c;

    assign accept_c  = in_valid & in_ready;
    assign sel_oob_c = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN));

    always_comb begin
        sel_err_d = sel_err_q;
        if (accept_c && sel_oob_c) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(accept_c && sel_oob_c))
            else $warning("mux_n_1_pipe: accepted out-of-range select %0d", in_sel);
        end
    end
`endif
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Randomized + directed bench for mux_n_1_pipe with a queue-based reference model.
module tb_mux_n_1_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SEL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // DUT A: default 4 x 5
    logic [19:0] a_in_data;
    logic [1:0]  a_in_sel;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sel_err;
    logic [4:0]  a_out_data;
    logic [1:0]  a_out_sel;

    // DUT B: 3 x 8, non-power-of-two
    logic [23:0] b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_sel;

    // DUT C: minimum 2 x 5
    logic [9:0]  c_in_data;
    logic        c_in_sel;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_sel_err;
    logic [4:0]  c_out_data;
    logic        c_out_sel;

    mux_n_1_pipe #(.WIDTH(5), .NUM_IN(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sel_err(a_sel_err)
    );

    mux_n_1_pipe #(.WIDTH(8), .NUM_IN(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sel_err(b_sel_err)
    );

    mux_n_1_pipe #(.WIDTH(5), .NUM_IN(2)) u_dut_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_sel(c_in_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_sel(c_out_sel), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .sel_err(c_sel_err)
    );

    // Reference model for DUT A: in-flight transfers as {sel, word}, oldest first.
    logic [6:0] a_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic a_check(input string tag);
        logic [6:0] head;
        check({tag, ".valid"}, 32'(a_out_valid), 32'(a_q.size() > 0));
        check({tag, ".ready"}, 32'(a_in_ready), 32'(a_q.size() < 2));
        check({tag, ".err"}, 32'(a_sel_err), 32'(0));
        if (a_q.size() > 0) begin
            head = a_q[0];
            check({tag, ".data"}, 32'(a_out_data), 32'(head[4:0]));
            check({tag, ".sel"}, 32'(a_out_sel), 32'(head[6:5]));
        end
    endtask

    // One clock of DUT A, called just after a falling edge.
    task automatic a_cycle(input logic v, input logic [1:0] s, input logic [19:0] d,
                           input logic ordy, input string tag);
        logic acc, hand;
        logic [4:0] w;
        a_in_valid  = v;
        a_in_sel    = s;
        a_in_data   = d;
        a_out_ready = ordy;
        acc  = v && (a_q.size() < 2);
        hand = (a_q.size() > 0) && ordy;
        w    = 5'(d >> (5 * int'(s)));
        @(posedge clk);
        if (hand) void'(a_q.pop_front());
        if (acc) a_q.push_back({s, w});
        @(negedge clk);
        a_check(tag);
    endtask

    task automatic b_cycle(input logic v, input logic [1:0] s, input logic ordy);
        b_in_valid  = v;
        b_in_sel    = s;
        b_out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic c_cycle(input logic s);
        c_in_valid = 1'b1;
        c_in_sel   = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_in_valid = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_sel = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_sel = 1'b0; c_out_ready = 1'b1;
    endtask

    // Asserts reset between clock edges so the async clear is observable.
    task automatic do_reset(input string tag);
        #1 rst = 1'b1;
        idle_inputs();
        #1;
        check({tag, ".rst_a_valid"}, 32'(a_out_valid), 32'(0));
        check({tag, ".rst_a_data"}, 32'(a_out_data), 32'(0));
        check({tag, ".rst_a_sel"}, 32'(a_out_sel), 32'(0));
        check({tag, ".rst_a_ready"}, 32'(a_in_ready), 32'(0));
        check({tag, ".rst_b_valid"}, 32'(b_out_valid), 32'(0));
        check({tag, ".rst_b_err"}, 32'(b_sel_err), 32'(0));
        check({tag, ".rst_c_ready"}, 32'(c_in_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a_q.delete();
        check({tag, ".rel_a_ready"}, 32'(a_in_ready), 32'(1));
        check({tag, ".rel_a_valid"}, 32'(a_out_valid), 32'(0));
        check({tag, ".rel_b_ready"}, 32'(b_in_ready), 32'(1));
        check({tag, ".rel_c_ready"}, 32'(c_in_ready), 32'(1));
    endtask

    initial begin
        int exp_basic[4];
        logic [19:0] basic_data;
        logic [19:0] bp_data;

        idle_inputs();
        b_in_data = {8'hAA, 8'h55, 8'h0F};
        c_in_data = {5'd12, 5'd7};
        do_reset("init");

        // Basic select at full throughput.
        basic_data = {5'd31, 5'd17, 5'd9, 5'd3};
        exp_basic  = '{3, 9, 17, 31};
        for (int i = 0; i < 4; i++) begin
            a_cycle(1'b1, 2'(i), basic_data, 1'b1, "basic");
            check("basic.const_data", 32'(a_out_data), 32'(exp_basic[i]));
            check("basic.const_sel", 32'(a_out_sel), 32'(i));
            check("basic.const_valid", 32'(a_out_valid), 32'(1));
        end
        a_cycle(1'b0, 2'd0, 20'd0, 1'b1, "basic_drain");

        // Backpressure: A then B held, then released in order.
        bp_data = {5'd4, 5'd22, 5'd13, 5'd1};
        a_cycle(1'b1, 2'd1, bp_data, 1'b0, "bp_a");
        a_cycle(1'b1, 2'd2, bp_data, 1'b0, "bp_b");
        check("bp.ready_low", 32'(a_in_ready), 32'(0));
        check("bp.hold_a", 32'(a_out_data), 32'(13));
        a_cycle(1'b0, 2'd0, 20'd0, 1'b0, "bp_stall");
        check("bp.still_a", 32'(a_out_data), 32'(13));
        a_cycle(1'b0, 2'd0, 20'd0, 1'b1, "bp_rel1");
        check("bp.out_b", 32'(a_out_data), 32'(22));
        check("bp.ready_back", 32'(a_in_ready), 32'(1));
        a_cycle(1'b0, 2'd0, 20'd0, 1'b1, "bp_rel2");
        check("bp.empty", 32'(a_out_valid), 32'(0));

        // Reset with two entries held.
        a_cycle(1'b1, 2'd3, bp_data, 1'b0, "mid_a");
        a_cycle(1'b1, 2'd0, bp_data, 1'b0, "mid_b");
        do_reset("mid");

        // Out-of-range select on a 3-input mux.
        b_cycle(1'b1, 2'd3, 1'b1);
        check("oob.valid", 32'(b_out_valid), 32'(1));
        check("oob.data", 32'(b_out_data), 32'(8'h00));
        check("oob.sel", 32'(b_out_sel), 32'(3));
        check("oob.err", 32'(b_sel_err), 32'(EXP_ERR));
        b_cycle(1'b1, 2'd2, 1'b1);
        check("oob.in2", 32'(b_out_data), 32'(8'hAA));
        b_cycle(1'b1, 2'd0, 1'b1);
        check("oob.in0", 32'(b_out_data), 32'(8'h0F));
        b_cycle(1'b1, 2'd1, 1'b1);
        check("oob.in1", 32'(b_out_data), 32'(8'h55));
        b_cycle(1'b0, 2'd0, 1'b1);
        check("oob.idle", 32'(b_out_valid), 32'(0));
        check("oob.err_sticky", 32'(b_sel_err), 32'(EXP_ERR));

        // Minimum configuration: alternating 2:1 select.
        for (int i = 0; i < 4; i++) begin
            c_cycle(1'(i));
            check("min.data", 32'(c_out_data), (i % 2 == 0) ? 32'd7 : 32'd12);
            check("min.sel", 32'(c_out_sel), 32'(i % 2));
            check("min.valid", 32'(c_out_valid), 32'(1));
            check("min.err", 32'(c_sel_err), 32'(0));
        end
        c_in_valid = 1'b0;
        do_reset("post_min");

        // Random stress against the model.
        for (int i = 0; i < 10000; i++) begin
            a_cycle($urandom_range(0, 3) != 0, 2'($urandom), 20'($urandom),
                    $urandom_range(0, 2) != 0, "rand");
        end
        for (int i = 0; i < 3; i++) begin
            a_cycle(1'b0, 2'd0, 20'd0, 1'b1, "rand_drain");
        end
        check("rand.drained", 32'(a_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
